// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered clock, 11-bit frame FSM and show-ahead byte FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits do not hold an odd number of ones.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kbd_clk,
  input  logic                          kbd_data,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    Keyboard_Data,
  output logic                          ready_pulse,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------
  // Two-flop synchronisers; bit 0 = kbd_clk, bit 1 = kbd_data
  // ---------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] sync_bits;
  logic       clk_sync;
  logic       data_sync;

  assign raw_in = {kbd_data, kbd_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_bits[gi] = s2_reg;
    end
  endgenerate

  assign clk_sync  = sync_bits[0];
  assign data_sync = sync_bits[1];

  // ---------------------------------------------------------------
  // Clock filter: follow clk_sync only after FILTER_LEN differing samples
  // ---------------------------------------------------------------
  logic          filt_reg, filt_next;
  logic [FW-1:0] fcnt_reg, fcnt_next;
  logic          sample_evt;

  always_comb begin
    filt_next  = filt_reg;
    fcnt_next  = '0;
    sample_evt = 1'b0;
    if (clk_sync != filt_reg) begin
      if (fcnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_next  = clk_sync;
        sample_evt = filt_reg;   // 1 -> 0 transition of the filtered clock
      end else begin
        fcnt_next = fcnt_reg + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_reg <= 1'b1;
      fcnt_reg <= '0;
    end else begin
      filt_reg <= filt_next;
      fcnt_reg <= fcnt_next;
    end
  end

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          push_req;
  logic          frame_set;
  logic          frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_reg, par_next;
  assign frame_ok = data_sync && (^{shift_reg, par_reg});
`else
  assign frame_ok = data_sync;
`endif

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tmo_next     = '0;
    push_req     = 1'b0;
    frame_set    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_next     = par_reg;
`endif
    if (state_reg != IDLE && !sample_evt)
      tmo_next = tmo_reg + TW'(1);

    case (state_reg)
      IDLE: begin
        if (sample_evt && !data_sync) begin
          state_next   = DATA;
          bit_cnt_next = 3'd0;
        end
      end
      DATA: begin
        if (sample_evt) begin
          shift_next   = {data_sync, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7)
            state_next = PARITY;
        end
      end
      PARITY: begin
        if (sample_evt) begin
`ifdef PS2_PARITY_CHECK_EN
          par_next   = data_sync;
`endif
          state_next = STOP;
        end
      end
      STOP: begin
        if (sample_evt) begin
          state_next = IDLE;
          if (frame_ok)
            push_req = 1'b1;
          else
            frame_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A stalled frame is abandoned; the partial byte is thrown away
    if (state_reg != IDLE && !sample_evt && tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
      state_next = IDLE;
      shift_next = '0;
      tmo_next   = '0;
      frame_set  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tmo_reg     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tmo_reg     <= tmo_next;
`ifdef PS2_PARITY_CHECK_EN
      par_reg     <= par_next;
`endif
    end
  end

  // ---------------------------------------------------------------
  // Byte FIFO (show-ahead head)
  // ---------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          do_pop, do_push, ovf_set;
  logic          ready_reg, ovf_reg, ferr_reg;

  assign do_pop  = rd_en && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign do_push = push_req && ((count_reg != CW'(FIFO_DEPTH)) || do_pop);
  assign ovf_set = push_req && !do_push;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      ferr_reg   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      ready_reg <= do_push;
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (err_clr)
        ovf_reg <= 1'b0;
      if (frame_set)
        ferr_reg <= 1'b1;
      else if (err_clr)
        ferr_reg <= 1'b0;
    end
  end

  assign Keyboard_Data = (count_reg == '0) ? 8'h00 : mem[rd_ptr_reg];
  assign ready_pulse   = ready_reg;
  assign empty         = (count_reg == '0);
  assign full          = (count_reg == CW'(FIFO_DEPTH));
  assign count         = count_reg;
  assign overflow      = ovf_reg;
  assign frame_err     = ferr_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed vector table, hand-written corner sequences,
// and randomized frames checked against a transaction-level queue model.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int FL    = 4;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       kbd_clk = 1'b1;
  logic       kbd_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] Keyboard_Data;
  logic       ready_pulse, empty, full, overflow, frame_err;
  logic [$clog2(DEPTH):0] count;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .kbd_clk(kbd_clk), .kbd_data(kbd_data),
    .rd_en(rd_en), .err_clr(err_clr), .Keyboard_Data(Keyboard_Data),
    .ready_pulse(ready_pulse), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int doubles = 0;
  logic rp_prev = 1'b0;

  always @(negedge clk) begin
    if (ready_pulse === 1'b1) begin
      pulses++;
      if (rp_prev) doubles++;
    end
    rp_prev = ready_pulse;
  end

  // Transaction-level model
  logic [7:0] q[$];
  bit m_ovf, m_ferr;
  int exp_pulses, pbase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit frame_valid(input logic [7:0] d, input logic par, input logic stop);
`ifdef PS2_PARITY_CHECK_EN
    return stop && ($countones({d, par}) % 2 == 1);
`else
    return stop;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_ferr = 0;
    exp_pulses = 0;
    pbase = pulses;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    if (frame_valid(d, par, stop)) begin
      if (q.size() < DEPTH) begin
        q.push_back(d);
        exp_pulses++;
      end else m_ovf = 1;
    end else m_ferr = 1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, "_head"}, 32'(Keyboard_Data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    check({tag, "_pulses"}, 32'(pulses - pbase), 32'(exp_pulses));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    kbd_data = b;
    idle(1);
    if (glitch) begin
      kbd_clk = 1'b0;
      idle(FL - 1);
      kbd_clk = 1'b1;
    end
    idle(4);
    kbd_clk = 1'b0;
    idle(10);
    kbd_clk = 1'b1;
    idle(6);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch_bit == i);
    ps2_bit(par, 0);
    ps2_bit(stop, 0);
    kbd_data = 1'b1;
    idle(4);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    m_ovf = 0; m_ferr = 0;
  endtask

  task automatic do_reset(input string tag);
    kbd_clk = 1'b1; kbd_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    reset = 1'b1;
    #1;
    check({tag, "_rst_empty"}, 32'(empty), 32'd1);
    check({tag, "_rst_count"}, 32'(count), 32'd0);
    check({tag, "_rst_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_rst_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_rst_data"}, 32'(Keyboard_Data), 32'd0);
    idle(3);
    reset = 1'b0;
    idle(3);
    model_reset();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] exp_head;
    int         exp_count;
    logic       exp_ferr;
    int         pops;
    int         exp_after;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int p0, seen, cnt_before;
    logic [7:0] rb;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 1'b0, 1, 0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1, 0};
`else
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1, 1'b0, 1, 0};
`endif
    vecs[2] = '{8'h55, 1'b1, 1'b0, 8'h00, 0, 1'b1, 0, 0};
    vecs[3] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1, 1'b0, 0, 1};
    vecs[4] = '{8'h7E, 1'b1, 1'b1, 8'hA3, 2, 1'b0, 2, 0};

    #2;
    check("init_empty", 32'(empty), 32'd1);
    check("init_full", 32'(full), 32'd0);
    check("init_pulse", 32'(ready_pulse), 32'd0);
    check("init_data", 32'(Keyboard_Data), 32'd0);
    do_reset("boot");

    // Push timing: count, head and ready_pulse all change together after the stop sample
    p0 = pulses;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(rb_const(8'h1C, i), 0);
    ps2_bit(1'b0, 0);
    kbd_data = 1'b1;
    idle(4);
    kbd_clk = 1'b0;
    seen = 0;
    cnt_before = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cnt_before = int'(count);
      idle(1);
      if (ready_pulse === 1'b1) seen = 1;
    end
    check("timed_seen", 32'(seen), 32'd1);
    check("timed_prev_count", 32'(cnt_before), 32'd0);
    check("timed_count", 32'(count), 32'd1);
    check("timed_head", 32'(Keyboard_Data), 32'h1C);
    idle(1);
    check("timed_pulse_low", 32'(ready_pulse), 32'd0);
    kbd_clk = 1'b1;
    idle(6);
    check("timed_pulses", 32'(pulses - p0), 32'd1);
    pop_one();
    check("timed_pop_empty", 32'(empty), 32'd1);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].d, vecs[v].par, vecs[v].stop, -1);
      check($sformatf("vec%0d_head", v), 32'(Keyboard_Data), 32'(vecs[v].exp_head));
      check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
      check($sformatf("vec%0d_ferr", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
      for (int p = 0; p < vecs[v].pops; p++) pop_one();
      check($sformatf("vec%0d_after", v), 32'(count), 32'(vecs[v].exp_after));
      clear_err();
      check($sformatf("vec%0d_clr", v), 32'(frame_err), 32'd0);
    end

    // Overflow with depth 4
    do_reset("ovf");
    p0 = pulses;
    for (int f = 1; f <= 5; f++) send_frame(8'(f), ~(^8'(f)), 1'b1, -1);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_pulses", 32'(pulses - p0), 32'd4);
    for (int f = 1; f <= 4; f++) begin
      check($sformatf("ovf_pop%0d", f), 32'(Keyboard_Data), 32'(f));
      pop_one();
    end
    check("ovf_drained", 32'(empty), 32'd1);

    // Push and pop in the same cycle while full
    clear_err();
    for (int f = 1; f <= 4; f++) send_frame(8'(f + 8'h10), ~(^8'(f + 8'h10)), 1'b1, -1);
    p0 = pulses;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(rb_const(8'h15, i), 0);
    ps2_bit(~(^8'h15), 0);
    kbd_data = 1'b1;
    idle(4);
    kbd_clk = 1'b0;
    idle(5);
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    idle(4);
    kbd_clk = 1'b1;
    idle(6);
    check("pp_count", 32'(count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_pulses", 32'(pulses - p0), 32'd1);
    for (int f = 2; f <= 5; f++) begin
      check($sformatf("pp_pop%0d", f), 32'(Keyboard_Data), 32'(f + 8'h10));
      pop_one();
    end

    // Timeout mid-frame, then a good frame
    do_reset("tmo");
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
    idle(TMO + 10);
    m_ferr = 1;
    compare_model("tmo");
    clear_err();
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    model_frame(8'hF0, 1'b1, 1'b1);
    compare_model("tmo_next");

    // Clock glitch shorter than the filter inside a frame
    send_frame(8'h5A, 1'b1, 1'b1, 3);
    model_frame(8'h5A, 1'b1, 1'b1);
    compare_model("glitch");
    pop_one();
    pop_one();
    check("glitch_pop_empty", 32'(empty), 32'd1);

    // Reset after 4 data bits
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(rb_const(8'h29, i), 0);
    do_reset("midrst");
    send_frame(8'h29, 1'b0, 1'b1, -1);
    model_frame(8'h29, 1'b0, 1'b1);
    compare_model("midrst_next");

    // Randomized frames against the model
    do_reset("rand");
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d;
      logic par, stop;
      d = 8'($urandom);
      par = ($urandom_range(0, 3) != 0) ? ~(^d) : (^d);
      stop = ($urandom_range(0, 9) != 0);
      send_frame(d, par, stop, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1);
      model_frame(d, par, stop);
      compare_model($sformatf("rand%0d", it));
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        check($sformatf("rand%0d_rd", it), 32'(Keyboard_Data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        pop_one();
      end
      if ($urandom_range(0, 3) == 0) clear_err();
    end
    compare_model("rand_end");

    check("no_double_pulse", 32'(doubles), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic rb_const(input logic [7:0] v, input int i);
    return v[i];
  endfunction

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
